// File: rtl/bitstream_pkg.sv
// Shared bitstream constants, writer FSM states and the code-length clamp
// used by putbits and by getbits/VLD test code.
package bitstream_pkg;

   localparam int WORD_W = 64;
   localparam int CODE_W = 24;
   localparam int LEN_W  = 5;
   localparam int FILL_W = 7;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } putbits_state_t;

   function automatic logic [LEN_W-1:0] len_clamp(input logic [LEN_W-1:0] len);
      if (len > LEN_W'(CODE_W)) begin
         return LEN_W'(CODE_W);
      end else begin
         return len;
      end
   endfunction

endpackage

// File: rtl/putbits_merge.sv
// Combinational merge of one right-justified code (plus optional byte
// alignment) into the MSB-first word buffer; reports a completed word.
module putbits_merge
   import bitstream_pkg::*;
(
   input  logic [WORD_W-1:0] wbuf,
   input  logic [FILL_W-1:0] fill,
   input  logic [CODE_W-1:0] code,
   input  logic [LEN_W-1:0]  len,
   input  logic              align,
   output logic [WORD_W-1:0] next_wbuf,
   output logic [FILL_W-1:0] next_fill,
   output logic [WORD_W-1:0] word_out,
   output logic              word_done
);

   logic [CODE_W-1:0]   code_mask_s;
   logic [2*WORD_W-1:0] code_ext_s;
   logic [2*WORD_W-1:0] merged_s;
   logic [7:0]          total_s;
   logic [7:0]          padded_s;
   logic [7:0]          shift_s;

   // Buffer bits below fill are always zero, so OR-ing the shifted code and
   // rounding the count up to a byte both yield zero padding for free.
   always_comb begin
      code_mask_s = ~({CODE_W{1'b1}} << len);
      total_s     = {1'b0, fill} + {3'b000, len};
      padded_s    = align ? ((total_s + 8'd7) & 8'hF8) : total_s;
      shift_s     = 8'd128 - total_s;
      code_ext_s  = {{(2*WORD_W-CODE_W){1'b0}}, code & code_mask_s} << shift_s;
      merged_s    = {wbuf, {WORD_W{1'b0}}} | code_ext_s;
      word_out    = merged_s[2*WORD_W-1:WORD_W];
      if (padded_s >= 8'd64) begin
         word_done = 1'b1;
         next_wbuf = merged_s[WORD_W-1:0];
         next_fill = FILL_W'(padded_s - 8'd64);
      end else begin
         word_done = 1'b0;
         next_wbuf = merged_s[2*WORD_W-1:WORD_W];
         next_fill = FILL_W'(padded_s);
      end
   end

endmodule

// File: rtl/putbits.sv
// Bitstream writer: packs MSB-first codes into 64-bit FIFO words with align
// and end-of-stream flush. Define PUTBITS_BITCOUNT_EN to add bit_count.
module putbits
   import bitstream_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              putbits_valid,
   input  logic [CODE_W-1:0] putbits_data,
   input  logic [LEN_W-1:0]  putbits_len,
   input  logic              align,
   input  logic              flush,
   output logic              putbits_ready,
   output logic [WORD_W-1:0] vid_out,
   output logic              vid_out_wr_en,
   input  logic              vid_out_afull,
   output logic              flush_done
`ifdef PUTBITS_BITCOUNT_EN
   ,
   output logic [31:0]       bit_count
`endif
);

   putbits_state_t    state_r;
   logic [WORD_W-1:0] wbuf_r;
   logic [FILL_W-1:0] fill_r;
   logic              ready_r;
   logic [WORD_W-1:0] vid_out_r;
   logic              wr_en_r;
   logic              flush_done_r;

   logic [LEN_W-1:0]  eff_len_s;
   logic              eff_align_s;
   logic [WORD_W-1:0] m_next_wbuf_s;
   logic [FILL_W-1:0] m_next_fill_s;
   logic [WORD_W-1:0] m_word_out_s;
   logic              m_word_done_s;

   // ready_r is only ever high in RUN, so it alone qualifies the code.
   always_comb begin
      eff_len_s   = (ready_r & putbits_valid) ? len_clamp(putbits_len) : 5'd0;
      eff_align_s = ready_r & align;
   end

   putbits_merge u_merge (
      .wbuf      (wbuf_r),
      .fill      (fill_r),
      .code      (putbits_data),
      .len       (eff_len_s),
      .align     (eff_align_s),
      .next_wbuf (m_next_wbuf_s),
      .next_fill (m_next_fill_s),
      .word_out  (m_word_out_s),
      .word_done (m_word_done_s)
   );

   // Writer FSM: accept/merge in RUN, drain the partial word in FLUSH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= RUN;
         wbuf_r       <= {WORD_W{1'b0}};
         fill_r       <= 7'd0;
         ready_r      <= 1'b0;
         vid_out_r    <= {WORD_W{1'b0}};
         wr_en_r      <= 1'b0;
         flush_done_r <= 1'b0;
      end else if (!clk_en) begin
         wr_en_r      <= 1'b0;
         flush_done_r <= 1'b0;
      end else begin
         wr_en_r      <= 1'b0;
         flush_done_r <= 1'b0;
         case (state_r)
            RUN: begin
               if (ready_r) begin
                  wbuf_r <= m_next_wbuf_s;
                  fill_r <= m_next_fill_s;
                  if (m_word_done_s) begin
                     vid_out_r <= m_word_out_s;
                     wr_en_r   <= 1'b1;
                  end
               end
               if (ready_r && flush) begin
                  state_r <= FLUSH;
                  ready_r <= 1'b0;
               end else begin
                  ready_r <= ~vid_out_afull;
               end
            end
            FLUSH: begin
               ready_r <= 1'b0;
               if (fill_r == 7'd0) begin
                  state_r      <= DONE;
                  flush_done_r <= 1'b1;
               end else if (!vid_out_afull) begin
                  vid_out_r <= wbuf_r;
                  wr_en_r   <= 1'b1;
                  wbuf_r    <= {WORD_W{1'b0}};
                  fill_r    <= 7'd0;
               end
            end
            DONE: begin
               state_r <= RUN;
               ready_r <= ~vid_out_afull;
            end
            default: begin
               state_r <= RUN;
               ready_r <= 1'b0;
            end
         endcase
      end
   end

`ifdef PUTBITS_BITCOUNT_EN
   logic [31:0] bit_count_r;
   logic [7:0]  added_s;

   // Bits added by this accept, including any byte padding.
   always_comb begin
      added_s = {1'b0, m_next_fill_s} + (m_word_done_s ? 8'd64 : 8'd0) - {1'b0, fill_r};
   end

   // Running count of accepted bits plus align and flush padding.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_count_r <= 32'd0;
      end else if (clk_en && state_r == RUN && ready_r) begin
         bit_count_r <= bit_count_r + {24'd0, added_s};
      end else if (clk_en && state_r == FLUSH && fill_r != 7'd0 && !vid_out_afull) begin
         bit_count_r <= bit_count_r + {24'd0, 8'd64 - {1'b0, fill_r}};
      end else begin
         bit_count_r <= bit_count_r;
      end
   end

   assign bit_count = bit_count_r;
`endif

   assign putbits_ready = ready_r;
   assign vid_out       = vid_out_r;
   assign vid_out_wr_en = wr_en_r;
   assign flush_done    = flush_done_r;

endmodule

// File: tb/tb_putbits.sv
// Directed bench for putbits: a bit-queue model of the packed stream checks
// every emitted word and flush_done; literal checks pin the model.
module tb_putbits;
   import bitstream_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              clk_en;
   logic              putbits_valid;
   logic [CODE_W-1:0] putbits_data;
   logic [LEN_W-1:0]  putbits_len;
   logic              align;
   logic              flush;
   logic              putbits_ready;
   logic [WORD_W-1:0] vid_out;
   logic              vid_out_wr_en;
   logic              vid_out_afull;
   logic              flush_done;
`ifdef PUTBITS_BITCOUNT_EN
   logic [31:0]       bit_count;
`endif

   putbits dut (
      .clk           (clk),
      .rst           (rst),
      .clk_en        (clk_en),
      .putbits_valid (putbits_valid),
      .putbits_data  (putbits_data),
      .putbits_len   (putbits_len),
      .align         (align),
      .flush         (flush),
      .putbits_ready (putbits_ready),
      .vid_out       (vid_out),
      .vid_out_wr_en (vid_out_wr_en),
      .vid_out_afull (vid_out_afull),
      .flush_done    (flush_done)
`ifdef PUTBITS_BITCOUNT_EN
      ,
      .bit_count     (bit_count)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   bit          bits_q[$];
   logic [63:0] exp_words[$];
   int          exp_flush = 0;
   logic [31:0] model_bits = 32'd0;

   int          cyc = 0;
   int          nwords = 0;
   int          nfd = 0;
   int          word_cyc = 0;
   int          fd_cyc = 0;
   logic [63:0] last_word = 64'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: event did not occur within its bound", name);
   endtask

   function automatic logic [63:0] take_word();
      logic [63:0] w;
      w = 64'd0;
      for (int i = 0; i < 64; i++) w = {w[62:0], logic'(bits_q.pop_front())};
      return w;
   endfunction

   // Model: the stream is just a queue of bits; every 64 bits is one word.
   always begin
      @(posedge clk);
      if (rst) begin
         bits_q.delete();
         exp_words.delete();
         exp_flush  = 0;
         model_bits = 32'd0;
      end else if (clk_en && putbits_ready) begin
         int l;
         l = putbits_valid ? ((putbits_len > 5'd24) ? 24 : int'(putbits_len)) : 0;
         for (int i = l - 1; i >= 0; i--) begin
            bits_q.push_back(putbits_data[i]);
            model_bits = model_bits + 32'd1;
         end
         if (align) begin
            while (bits_q.size() % 8 != 0) begin
               bits_q.push_back(1'b0);
               model_bits = model_bits + 32'd1;
            end
         end
         if (bits_q.size() >= 64) exp_words.push_back(take_word());
         if (flush) begin
            if (bits_q.size() > 0) begin
               while (bits_q.size() < 64) begin
                  bits_q.push_back(1'b0);
                  model_bits = model_bits + 32'd1;
               end
               exp_words.push_back(take_word());
            end
            exp_flush++;
         end
      end
   end

   // Compare process: every emitted word and flush_done against the model.
   always begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
         if (vid_out_wr_en) begin
            if (exp_words.size() == 0) begin
               check("unexpected_word", vid_out, 64'd0);
               check("spurious_wr_en", 64'(vid_out_wr_en), 64'd0);
            end else begin
               check("word", vid_out, exp_words.pop_front());
            end
            last_word = vid_out;
            nwords++;
            word_cyc = cyc;
         end
         if (flush_done) begin
            check("flush_done_due", 64'(exp_flush > 0 && exp_words.size() == 0), 64'd1);
            if (exp_flush > 0) exp_flush--;
            nfd++;
            fd_cyc = cyc;
         end
      end
   end

   task automatic xfer(input logic [23:0] d, input logic [4:0] l, input logic v,
                       input logic a, input logic f, input logic gap);
      int n;
      n = 0;
      putbits_data  = d;
      putbits_len   = l;
      putbits_valid = v;
      align         = a;
      flush         = f;
      if (gap) begin
         clk_en = 1'b0;
         @(negedge clk);
         clk_en = 1'b1;
      end
      while (!(putbits_ready && clk_en) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) note_fail("ready_timeout");
      else @(negedge clk);
      putbits_valid = 1'b0;
      align         = 1'b0;
      flush         = 1'b0;
   endtask

   task automatic wait_words(input int target);
      int n;
      n = 0;
      while (nwords < target && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (nwords < target) note_fail("word_timeout");
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      int f0;
      rst = 1'b1; clk_en = 1'b0; putbits_valid = 1'b0; putbits_data = 24'd0;
      putbits_len = 5'd0; align = 1'b0; flush = 1'b0; vid_out_afull = 1'b0;
      idle(3);
      check("rst_ready", 64'(putbits_ready), 64'd0);
      check("rst_vid_out", vid_out, 64'd0);
      check("rst_wr_en", 64'(vid_out_wr_en), 64'd0);
      check("rst_flush_done", 64'(flush_done), 64'd0);
      rst = 1'b0;
      idle(1);
      check("ready_before_clk_en", 64'(putbits_ready), 64'd0);
      clk_en = 1'b1;
      idle(1);
      check("ready_after_clk_en", 64'(putbits_ready), 64'd1);

      // Eight bytes fill exactly one word.
      w0 = nwords;
      for (int i = 0; i < 8; i++) xfer(24'(i), 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_words(w0 + 1);
      check("t1_word", last_word, 64'h0001020304050607);

      // Flush with nothing buffered: no word, done two cycles later.
      w0 = nwords;
      check("t4_ready_pre", 64'(putbits_ready), 64'd1);
      flush = 1'b1;
      idle(1);
      flush = 1'b0;
      check("t4_ready_c1", 64'(putbits_ready), 64'd0);
      check("t4_done_c1", 64'(flush_done), 64'd0);
      idle(1);
      check("t4_ready_c2", 64'(putbits_ready), 64'd0);
      check("t4_done_c2", 64'(flush_done), 64'd1);
      idle(1);
      check("t4_ready_c3", 64'(putbits_ready), 64'd1);
      check("t4_done_c3", 64'(flush_done), 64'd0);
      check("t4_no_word", 64'(nwords - w0), 64'd0);

      // fill=60, then a 12-bit code splits across the word boundary.
      w0 = nwords;
      xfer(24'h123456, 5'd24, 1'b1, 1'b0, 1'b0, 1'b0);
      xfer(24'h789ABC, 5'd24, 1'b1, 1'b0, 1'b0, 1'b0);
      xfer(24'h000DEF, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
      xfer(24'hFFFABC, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_words(w0 + 1);
      check("t2_word", last_word, 64'h123456789ABCDEFA);
      xfer(24'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      wait_words(w0 + 2);
      check("t2_remainder", last_word, 64'hBC00000000000000);
      idle(4);

      // Align then flush; flush_done follows the padded word by one cycle.
      w0 = nwords;
      xfer(24'h000005, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      xfer(24'h0000FF, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      xfer(24'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      wait_words(w0 + 1);
      idle(4);
      check("t3_word", last_word, 64'hA0FF000000000000);
      check("t3_done_lag", 64'(fd_cyc - word_cyc), 64'd1);

      // Almost-full stall mid-stream.
      fork
         begin
            for (int i = 0; i < 30; i++)
               xfer(24'($urandom), 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
         end
         begin
            idle(5);
            vid_out_afull = 1'b1;
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               check("t5_ready_stall", 64'(putbits_ready), 64'd0);
            end
            vid_out_afull = 1'b0;
         end
      join
      xfer(24'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(6);

      // Random codes, lengths 0..31, sporadic align/flush and clk_en gaps.
      for (int i = 0; i < 150; i++) begin
         xfer(24'($urandom), 5'($urandom_range(0, 31)), ($urandom_range(0, 7) != 0),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 24) == 0),
              ($urandom_range(0, 9) == 0));
      end
      xfer(24'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(8);
      check("drain_words", 64'(exp_words.size()), 64'd0);
      check("drain_flushes", 64'(exp_flush), 64'd0);

      // Reset while a flush word is still owed.
      xfer(24'hFFFFFF, 5'd20, 1'b1, 1'b0, 1'b0, 1'b0);
      xfer(24'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      w0 = nwords;
      f0 = nfd;
      idle(1);
      check("abort_ready", 64'(putbits_ready), 64'd0);
      check("abort_vid_out", vid_out, 64'd0);
      check("abort_wr_en", 64'(vid_out_wr_en), 64'd0);
      check("abort_flush_done", 64'(flush_done), 64'd0);
      idle(2);
      rst = 1'b0;
      idle(6);
      check("abort_no_word", 64'(nwords - w0), 64'd0);
      check("abort_no_done", 64'(nfd - f0), 64'd0);

      w0 = nwords;
      xfer(24'h5A5A5A, 5'd24, 1'b1, 1'b0, 1'b1, 1'b0);
      wait_words(w0 + 1);
      idle(4);
      check("post_abort_word", last_word, 64'h5A5A5A0000000000);
`ifdef PUTBITS_BITCOUNT_EN
      check("bit_count", 64'(bit_count), 64'(model_bits));
      check("bit_count_lit", 64'(bit_count), 64'd64);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
